board_renderer: RTL and testbench
=================================

BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 Parameter X0, default 24, screen x of the left edge of board cell (0,0).
REQ-002 Parameter Y0, default 4, screen y of the top edge of board cell (0,0).
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to render one full board pass.
REQ-006 mode_fg  input  1  sampled with start: 0 = background pass, 1 = foreground pass.
REQ-007 mem_data  input  2  board memory read data: 0 empty, 1 red, 2 blue, 3 bomb.
REQ-008 mem_read  output  1  board memory read enable.
REQ-009 mem_address  output  8  board memory address, equal to cell_y*16 + cell_x.
REQ-010 x  output  8  VGA pixel x.
REQ-011 y  output  7  VGA pixel y.
REQ-012 colour  output  3  VGA pixel colour {R,G,B}.
REQ-013 plot  output  1  VGA plot enable; x, y and colour are valid only while plot=1.
REQ-014 busy  output  1  high while a pass is in progress.
REQ-015 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-016 Board: 16x16 cells, each cell 7x7 pixels; cells scanned in raster order, x fastest; pixels within a cell scanned in raster order, px fastest.
REQ-017 Pixel coordinates: x = X0 + cell_x*7 + px and y = Y0 + cell_y*7 + py, with px and py in the range 0..6.
REQ-018 FSM states: IDLE, FETCH, WAIT1, WAIT2, PAINT, NEXT, DONE.
REQ-019 IDLE: when start=1, latch mode_fg, clear the cell and pixel counters, and go to FETCH (fg) or PAINT (bg) on the next edge; otherwise stay in IDLE.
REQ-020 FETCH: mem_read=1 and mem_address=current cell index for exactly one cycle; go to WAIT1.
REQ-021 WAIT1 -> WAIT2; mem_data is sampled into the cell register at the end of WAIT2.
REQ-022 WAIT2: if the sampled code is 0, go to NEXT (no plots); otherwise go to PAINT.
REQ-023 PAINT: plot=1 for each of the 49 cycles; px/py advance every cycle; after pixel (6,6), go to NEXT.
REQ-024 Background colour: 3'b010 when (cell_x XOR cell_y) bit0 = 1, otherwise 3'b000; memory is not read in background mode.
REQ-025 Foreground colour: code 1 = 3'b100, code 2 = 3'b001, code 3 = 3'b111.
REQ-026 NEXT: if the cell index is 255, go to DONE; otherwise increment the index (8-bit, no wrap used) and go to FETCH (fg) or PAINT (bg).
REQ-027 DONE: done=1 for one cycle, then go to IDLE.
REQ-028 busy=1 in every state except IDLE; busy is 0 in the cycle where start is sampled.
REQ-029 start is ignored in every state except IDLE, including DONE.
REQ-030 When plot=0, x, y and colour SHALL be 0; when mem_read=0, mem_address SHALL be 0.
REQ-031 Background pass length: exactly 12544 plot cycles.
REQ-032 Foreground pass length: 49 plot cycles per non-empty cell and zero for each empty cell.

Reset
REQ-033 reset=1 at a rising edge forces IDLE and sets mem_read, mem_address, x, y, colour, plot, busy and done to 0.
REQ-034 Reset clears the cell, pixel and cell-data registers and the latched mode, and has priority over start.
REQ-035 Reset asserted mid-pass aborts the pass with no done pulse; the next start restarts at cell 0, pixel 0.

Verification
REQ-036 Reset: hold reset 2 cycles with start=1 -> all outputs 0, busy stays 0, no plot.
REQ-037 Background: start with mode_fg=0 -> first plot at x=24, y=4, colour=000; first pixel of cell (1,0) at x=31, colour=010; 12544 plots total; mem_read never 1; exactly one done.
REQ-038 Foreground single cell: memory all 0 except address 35 = 1 -> 256 FETCH reads; exactly 49 plots with x in 45..51, y in 18..24, colour=100; one done.
REQ-039 Foreground corner: address 255 = 3, all other cells 0 -> last plot at x=135, y=115, colour=111; done in the cycle after NEXT.
REQ-040 Start while busy: pulse start mid-PAINT and again in the DONE cycle -> no restart and exactly one done; a start after IDLE is re-entered begins a new pass.
REQ-041 Reset mid-pass: assert reset during PAINT of cell 10 -> plot=0 and busy=0 the next cycle with no done; a new start yields a first plot at x=24, y=4.

Source files
------------

// File: rtl/board_renderer_if.sv
// Board renderer bus: start/mode request, board memory read port and VGA pixel stream.
// The master side owns the board memory and the pixel sink; the slave is the renderer.
interface board_renderer_if;
   logic       start;
   logic       mode_fg;
   logic [1:0] mem_data;
   logic       mem_read;
   logic [7:0] mem_address;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output start,
      output mode_fg,
      output mem_data,
      input  mem_read,
      input  mem_address,
      input  x,
      input  y,
      input  colour,
      input  plot,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  mode_fg,
      input  mem_data,
      output mem_read,
      output mem_address,
      output x,
      output y,
      output colour,
      output plot,
      output busy,
      output done
   );
endinterface

// File: rtl/board_renderer.sv
// Renders a 16x16 board of 7x7-pixel cells to a VGA plotter, either as a checkerboard
// background pass or as a foreground pass driven by a two-bit code per cell from board memory.
module board_renderer #(
   parameter int X0 = 24,
   parameter int Y0 = 4
) (
   input logic             clock,
   input logic             reset,
   board_renderer_if.slave bus
);

   localparam logic [7:0] LP_X0        = 8'(X0);
   localparam logic [6:0] LP_Y0        = 7'(Y0);
   localparam logic [7:0] LP_LAST_CELL = 8'd255;
   localparam logic [2:0] LP_LAST_PIX  = 3'd6;
   localparam logic [7:0] LP_CELL_W    = 8'd7;
   localparam logic [6:0] LP_CELL_H    = 7'd7;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT1 = 3'd2,
      S_WAIT2 = 3'd3,
      S_PAINT = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic       r_mode_fg;
   logic [7:0] r_cell_idx;
   logic [2:0] r_px;
   logic [2:0] r_py;
   logic [1:0] r_cell_code;

   logic [3:0] w_cell_x;
   logic [3:0] w_cell_y;
   logic       w_last_pixel;
   logic [7:0] w_pix_x;
   logic [6:0] w_pix_y;
   logic [2:0] w_pix_colour;

   function automatic logic [2:0] fg_colour(input logic [1:0] code);
      logic [2:0] c;
      case (code)
         2'd1:    c = 3'b100;
         2'd2:    c = 3'b001;
         2'd3:    c = 3'b111;
         default: c = 3'b000;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] bg_colour(input logic cx0, input logic cy0);
      logic [2:0] c;
      if ((cx0 ^ cy0) == 1'b1) begin
         c = 3'b010;
      end else begin
         c = 3'b000;
      end
      return c;
   endfunction

   assign w_cell_x     = r_cell_idx[3:0];
   assign w_cell_y     = r_cell_idx[7:4];
   assign w_last_pixel = (r_px == LP_LAST_PIX) && (r_py == LP_LAST_PIX);
   assign w_pix_x      = LP_X0 + ({4'd0, w_cell_x} * LP_CELL_W) + {5'd0, r_px};
   assign w_pix_y      = LP_Y0 + ({3'd0, w_cell_y} * LP_CELL_H) + {4'd0, r_py};
   assign w_pix_colour = r_mode_fg ? fg_colour(r_cell_code) : bg_colour(w_cell_x[0], w_cell_y[0]);

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; WAIT2 branches on the memory word arriving in that cycle
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_next_state = bus.mode_fg ? S_FETCH : S_PAINT;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FETCH: w_next_state = S_WAIT1;
         S_WAIT1: w_next_state = S_WAIT2;
         S_WAIT2: begin
            if (bus.mem_data == 2'd0) begin
               w_next_state = S_NEXT;
            end else begin
               w_next_state = S_PAINT;
            end
         end
         S_PAINT: begin
            if (w_last_pixel) begin
               w_next_state = S_NEXT;
            end else begin
               w_next_state = S_PAINT;
            end
         end
         S_NEXT: begin
            if (r_cell_idx == LP_LAST_CELL) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = r_mode_fg ? S_FETCH : S_PAINT;
            end
         end
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Cell index, pixel counters, cell code and latched pass mode
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mode_fg   <= 1'b0;
         r_cell_idx  <= 8'd0;
         r_px        <= 3'd0;
         r_py        <= 3'd0;
         r_cell_code <= 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mode_fg   <= bus.mode_fg;
                  r_cell_idx  <= 8'd0;
                  r_px        <= 3'd0;
                  r_py        <= 3'd0;
                  r_cell_code <= 2'd0;
               end
            end
            S_WAIT2: r_cell_code <= bus.mem_data;
            S_PAINT: begin
               if (r_px == LP_LAST_PIX) begin
                  r_px <= 3'd0;
                  r_py <= (r_py == LP_LAST_PIX) ? 3'd0 : (r_py + 3'd1);
               end else begin
                  r_px <= r_px + 3'd1;
               end
            end
            S_NEXT: begin
               if (r_cell_idx != LP_LAST_CELL) begin
                  r_cell_idx <= r_cell_idx + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode from registered state; idle outputs are forced to zero
   always_comb begin
      bus.mem_read    = 1'b0;
      bus.mem_address = 8'd0;
      bus.x           = 8'd0;
      bus.y           = 7'd0;
      bus.colour      = 3'd0;
      bus.plot        = 1'b0;
      bus.busy        = (r_state != S_IDLE);
      bus.done        = 1'b0;
      case (r_state)
         S_FETCH: begin
            bus.mem_read    = 1'b1;
            bus.mem_address = r_cell_idx;
         end
         S_PAINT: begin
            bus.plot   = 1'b1;
            bus.x      = w_pix_x;
            bus.y      = w_pix_y;
            bus.colour = w_pix_colour;
         end
         S_DONE:  bus.done = 1'b1;
         default: begin
            bus.plot = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: hand-derived single-cell vectors, reset and
// start-while-busy sequences, and random boards checked against a raster reference model.
module tb_board_renderer;

   typedef logic [17:0] pix_t;

   typedef struct {
      logic [7:0] addr;
      logic [1:0] code;
      int         plots;
      int         fx;
      int         fy;
      logic [2:0] fc;
      int         lx;
      int         ly;
      int         gap;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] mem [256];
   logic [7:0] rd_addr = 8'd0;

   board_renderer_if bus ();

   board_renderer #(.X0(24), .Y0(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // Board memory: address captured on a read, data held until the next read
   always @(posedge clock) begin
      if (bus.mem_read === 1'b1) rd_addr <= bus.mem_address;
   end
   assign bus.mem_data = mem[rd_addr];

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   reads, dones, addr_err, idle_nonzero, last_plot_cyc, done_cyc;
   pix_t cap[$];
   pix_t exp_q[$];
   int   exp_reads;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic pix_t pk(input int px, input int py, input int c);
      return {8'(px), 7'(py), 3'(c)};
   endfunction

   function automatic pix_t cap_at(input int i);
      if (i >= 0 && i < cap.size()) return cap[i];
      return 18'h3ffff;
   endfunction

   task automatic tick();
      @(negedge clock);
      cyc++;
      if (bus.plot === 1'b1) begin
         cap.push_back({bus.x, bus.y, bus.colour});
         last_plot_cyc = cyc;
      end else if ({bus.x, bus.y, bus.colour} !== 18'd0) begin
         idle_nonzero++;
      end
      if (bus.mem_read === 1'b1) begin
         if (bus.mem_address !== 8'(reads)) addr_err++;
         reads++;
      end else if (bus.mem_address !== 8'd0) begin
         addr_err++;
      end
      if (bus.done === 1'b1) begin
         dones++;
         done_cyc = cyc;
      end
   endtask

   task automatic clear_mon();
      cap.delete();
      reads = 0; dones = 0; addr_err = 0; idle_nonzero = 0;
      last_plot_cyc = 0; done_cyc = 0;
   endtask

   // Reference: walk the board in raster order and list every pixel that must be plotted
   task automatic build_expected(input logic fg);
      exp_q.delete();
      exp_reads = fg ? 256 : 0;
      for (int cy = 0; cy < 16; cy++) begin
         for (int cx = 0; cx < 16; cx++) begin
            int col;
            int code;
            code = int'(mem[cy * 16 + cx]);
            if (fg) begin
               col = (code == 1) ? 4 : (code == 2) ? 1 : 7;
            end else begin
               col = ((cx + cy) % 2 == 1) ? 2 : 0;
            end
            if (!fg || code != 0) begin
               for (int py = 0; py < 7; py++)
                  for (int px = 0; px < 7; px++)
                     exp_q.push_back(pk(24 + cx * 7 + px, 4 + cy * 7 + py, col));
            end
         end
      end
   endtask

   task automatic pulse_start(input logic fg);
      tick();
      chk("busy_in_start_cycle", 32'(bus.busy), 32'd0);
      bus.start = 1'b1;
      bus.mode_fg = fg;
      tick();
      bus.start = 1'b0;
      chk("busy_after_start", 32'(bus.busy), 32'd1);
   endtask

   task automatic compare_seq();
      int bad;
      int n;
      bad = 0;
      n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) bad++;
      chk("plot_count", 32'(cap.size()), 32'(exp_q.size()));
      chk("plot_seq_mismatches", 32'(bad), 32'd0);
   endtask

   task automatic run_pass(input logic fg, input int budget);
      clear_mon();
      build_expected(fg);
      pulse_start(fg);
      for (int i = 0; i < budget && dones == 0; i++) tick();
      chk("done_within_budget", 32'(dones > 0), 32'd1);
      repeat (3) tick();
      chk("busy_after_pass", 32'(bus.busy), 32'd0);
      chk("done_pulses", 32'(dones), 32'd1);
      chk("mem_reads", 32'(reads), 32'(exp_reads));
      chk("mem_addr_errors", 32'(addr_err), 32'd0);
      chk("idle_pixel_nonzero", 32'(idle_nonzero), 32'd0);
      compare_seq();
   endtask

   initial begin
      vecs[0] = '{8'd35,  2'd1, 49, 45,  18,  3'b100, 51,  24,  882};
      vecs[1] = '{8'd255, 2'd3, 49, 129, 109, 3'b111, 135, 115, 2};
      vecs[2] = '{8'd0,   2'd2, 49, 24,  4,   3'b001, 30,  10,  1022};
      vecs[3] = '{8'd15,  2'd1, 49, 129, 4,   3'b100, 135, 10,  962};
      vecs[4] = '{8'd240, 2'd2, 49, 24,  109, 3'b001, 30,  115, 62};
      vecs[5] = '{8'd100, 2'd0, 0,  0,   0,   3'b000, 0,   0,   0};
      for (int i = 0; i < 256; i++) mem[i] = 2'd0;
      clear_mon();

      // Reset held two cycles with start asserted
      reset = 1'b1;
      bus.start = 1'b1;
      bus.mode_fg = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("reset_outputs_zero", 32'({bus.mem_read, bus.mem_address, bus.x, bus.y, bus.colour,
                                        bus.plot, bus.busy, bus.done}), 32'd0);
      end
      reset = 1'b0;
      bus.start = 1'b0;
      tick();
      chk("idle_after_reset", 32'({bus.busy, bus.plot}), 32'd0);

      // Background pass
      run_pass(1'b0, 14000);
      chk("bg_first_pixel", 32'(cap_at(0)), 32'(pk(24, 4, 0)));
      chk("bg_cell1_first_pixel", 32'(cap_at(49)), 32'(pk(31, 4, 2)));

      // Table of single-cell foreground boards
      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 256; i++) mem[i] = 2'd0;
         mem[vecs[v].addr] = vecs[v].code;
         run_pass(1'b1, 3000);
         chk("vec_plots", 32'(cap.size()), 32'(vecs[v].plots));
         if (vecs[v].plots > 0) begin
            chk("vec_first_pixel", 32'(cap_at(0)), 32'(pk(vecs[v].fx, vecs[v].fy, int'(vecs[v].fc))));
            chk("vec_last_pixel", 32'(cap_at(cap.size() - 1)),
                32'(pk(vecs[v].lx, vecs[v].ly, int'(vecs[v].fc))));
            chk("vec_done_gap", 32'(done_cyc - last_plot_cyc), 32'(vecs[v].gap));
         end
      end

      // Start pulses mid-PAINT and in the DONE cycle are ignored
      for (int i = 0; i < 256; i++) mem[i] = 2'd0;
      mem[5] = 2'd2;
      mem[255] = 2'd1;
      clear_mon();
      build_expected(1'b1);
      pulse_start(1'b1);
      for (int i = 0; i < 200 && cap.size() < 10; i++) tick();
      bus.start = 1'b1;
      bus.mode_fg = 1'b0;
      tick();
      bus.start = 1'b0;
      chk("busy_start_mid_paint", 32'(bus.plot), 32'd1);
      for (int i = 0; i < 3000 && dones == 0; i++) tick();
      chk("busy_test_done_seen", 32'(dones), 32'd1);
      bus.start = 1'b1;
      bus.mode_fg = 1'b0;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      chk("no_restart_from_done", 32'({bus.busy, bus.plot}), 32'd0);
      chk("busy_test_dones", 32'(dones), 32'd1);
      compare_seq();

      // Random boards; a start from IDLE begins a fresh pass
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 2 * r + 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         run_pass(1'b1, 20000);
      end

      // Reset during PAINT of cell 10 aborts with no done
      clear_mon();
      pulse_start(1'b0);
      for (int i = 0; i < 1000 && cap_at(cap.size() - 1) !== pk(94, 4, 0); i++) tick();
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_plot_busy", 32'({bus.plot, bus.busy}), 32'd0);
      dones = 0;
      repeat (5) tick();
      chk("abort_no_done", 32'(dones), 32'd0);
      clear_mon();
      pulse_start(1'b0);
      chk("restart_first_pixel", 32'(cap_at(0)), 32'(pk(24, 4, 0)));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
